instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the main control decoder's opcode interface: turns an instruction class plus fields into a 32-bit MIPS word.
// - Streams encoded words into instruction memory at sequential addresses via a valid/ready input and a registered write port.
// - Used by the bench harness and the boot path to load programs into the single-cycle datapath's instruction memory before run.
// PARAMETERS
// - ADDR_W     8    instruction-memory word-address width
// - DEPTH      256  words available to load; DEPTH <= 2**ADDR_W
// - BASE_ADDR  0    word address of the first write after start
// PORTS
// - clk_i       in   1       clock; single clock domain
// - rst_i       in   1       synchronous, active-high reset
// - start_i     in   1       begin a load session (honoured in IDLE and DONE only)
// - valid_i     in   1       instruction fields valid
// - ready_o     out  1       loader can accept a word this cycle
// - kind_i      in   2       instruction class: 00 R-type, 01 lw, 10 sw, 11 beq
// - rs_i        in   5       rs field
// - rt_i        in   5       rt field
// - rd_i        in   5       rd field; R-type only
// - funct_i     in   6       funct field; R-type only
// - imm_i       in   16      immediate/offset; lw, sw, beq
// - last_i      in   1       word is final of program
// - memWrite_o  out  1       instruction-memory write strobe
// - memAddr_o   out  ADDR_W  write word address
// - memData_o   out  32      encoded instruction word
// - busy_o      out  1       session in progress (state LOAD)
// - done_o      out  1       session complete (state DONE)
// - count_o     out  ADDR_W+1  words written this session
// - overflow_o  out  1       sticky: DEPTH reached without last_i
// BEHAVIOUR
// - Encoding is purely combinational on the accepted fields. Unused fields are ignored.
//   - R-type: {000000, rs, rt, rd, 00000, funct}
//   - lw: {100011, rs, rt, imm}
//   - sw: {101011, rs, rt, imm}
//   - beq: {000100, rs, rt, imm}
// - Reset (rst_i=1 at an edge): state IDLE; all outputs 0; internal address = BASE_ADDR.
//   - Applies from any state, including mid-LOAD. An accepted-but-unwritten word is dropped; memWrite_o is 0 the next cycle.
// - FSM states IDLE, LOAD, DONE:
//   - IDLE -> LOAD on start_i: address = BASE_ADDR, count_o = 0, overflow_o = 0.
//   - In LOAD, start_i is ignored.
//   - LOAD -> DONE in the cycle after acceptance of either:
//     - a word with last_i = 1, or
//     - the DEPTH-th word, whether or not last_i is set.
//   - DONE -> LOAD on start_i, with the same clearing as IDLE -> LOAD; done_o stays 1 until then.
// - Handshake:
//   - ready_o = (state == LOAD) && (count_o < DEPTH). It is combinational from state; never depends on valid_i.
//   - Transfer occurs when valid_i && ready_o at a clock edge.
//   - valid_i while ready_o = 0 is ignored and never stalls or errors.
// - Latency: a word accepted at edge N produces memWrite_o = 1 for exactly the cycle after edge N.
//   - In that cycle, memAddr_o and memData_o hold the registered address and encoded word.
//   - Back-to-back transfers give one write per cycle with no bubbles.
// - When memWrite_o = 0, memAddr_o and memData_o hold their last values.
// - Address/count: address increments by 1 per accepted word, modulo 2**ADDR_W; count_o increments by 1.
//   - With BASE_ADDR + DEPTH > 2**ADDR_W the address wraps to 0. Wrapping is legal, not an error.
// - overflow_o: set when the DEPTH-th word is accepted with last_i = 0. It is sticky until the next start or reset.
// - Simultaneous events:
//   - last_i on the DEPTH-th word: overflow_o = 0, go to DONE.
//   - start_i together with valid_i in DONE: start is taken and the word is not accepted, because ready_o = 0 in DONE.
// TESTING
// - R add: rs=1, rt=2, rd=3, funct=0x20 accepted at edge N -> next cycle memWrite_o=1, memAddr_o=0, memData_o=0x00221820.
// - lw (rs=29, rt=8, imm=4), then sw (imm=8), then beq (rs=1, rt=2, imm=0xFFFF, last_i=1), back-to-back:
//   - writes 0x8FA80004, 0xAFA80008, 0x1022FFFF to addresses 0, 1, 2 on consecutive cycles;
//   - done_o=1 and count_o=3 the cycle after the last write's acceptance.
// - Random valid_i gaps over 20 words -> one write per transfer, addresses contiguous, no duplicates; start_i pulsed mid-LOAD has no effect.
// - DEPTH=4, five words with last_i=0 -> 4 writes, overflow_o=1, done_o=1, ready_o=0; fifth word never written.
// - rst_i asserted the cycle after an acceptance -> memWrite_o stays 0, all outputs 0, state IDLE, ready_o=0 until start_i.
// - BASE_ADDR=254, ADDR_W=8, three words -> addresses 254, 255, 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes MIPS instruction fields into 32-bit words and streams
// them into instruction memory at sequential word addresses.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic              last_i,
  output logic              memWrite_o,
  output logic [ADDR_W-1:0] memAddr_o,
  output logic [31:0]       memData_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic [31:0]       enc;
  logic              accept;

  always_comb begin
    enc = '0;
    unique case (kind_i)
      2'b00: enc = {OP_R, rs_i, rt_i,
                    rd_i, 5'b00000, funct_i};
      2'b01: enc = {OP_LW, rs_i, rt_i, imm_i};
      2'b10: enc = {OP_SW, rs_i, rt_i, imm_i};
      2'b11: enc = {OP_BEQ, rs_i, rt_i, imm_i};
    endcase
  end

  assign ready_o = (state_q == S_LOAD)
                && (cnt_q < DEPTH_C);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wr_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          addr_d  = BASE_C;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_d    = 1'b1;
          maddr_d = addr_q;
          mdata_d = enc;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // last_i wins over running out of room
          if (last_i) begin
            state_d = S_DONE;
          end else if (cnt_q == LAST_C) begin
            state_d = S_DONE;
            ovf_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_C;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  assign memWrite_o = wr_q;
  assign memAddr_o  = maddr_q;
  assign memData_o  = mdata_q;
  assign busy_o     = (state_q == S_LOAD);
  assign done_o     = (state_q == S_DONE);
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a default instance
// and a DEPTH=4 / BASE_ADDR=254 instance for overflow and wrap.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic start [2];
  logic valid [2];
  logic [1:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic        last;

  logic        rdy [2];
  logic        wr [2];
  logic        busy [2];
  logic        done [2];
  logic        ovf [2];
  logic [7:0]  maddr [2];
  logic [31:0] mdata [2];
  logic [8:0]  cnt [2];

  instr_encoder_loader u0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]),
    .valid_i(valid[0]), .ready_o(rdy[0]), .kind_i(kind),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(fn),
    .imm_i(imm), .last_i(last), .memWrite_o(wr[0]),
    .memAddr_o(maddr[0]), .memData_o(mdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .count_o(cnt[0]),
    .overflow_o(ovf[0])
  );

  instr_encoder_loader #(
    .ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)
  ) u1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]),
    .valid_i(valid[1]), .ready_o(rdy[1]), .kind_i(kind),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(fn),
    .imm_i(imm), .last_i(last), .memWrite_o(wr[1]),
    .memAddr_o(maddr[1]), .memData_o(mdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .count_o(cnt[1]),
    .overflow_o(ovf[1])
  );

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mx;

  int total = 0;
  int bad = 0;
  int ncyc = 0;

  localparam int DEP [2] = '{256, 4};
  localparam int BAS [2] = '{0, 254};

  int m_cnt [2];
  bit m_act [2];
  bit m_done [2];
  bit m_ovf [2];

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_enc();
    int op;
    logic [31:0] w;
    case (kind)
      2'd0: op = 0;
      2'd1: op = 35;
      2'd2: op = 43;
      default: op = 4;
    endcase
    w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16);
    if (kind == 2'd0) w = w | (32'(rd) << 11) | 32'(fn);
    else w = w | 32'(imm);
    return w;
  endfunction

  task automatic set_f(input logic [1:0] k, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d,
                       input logic [5:0] f, input logic [15:0] i);
    kind = k; rs = s; rt = t; rd = d; fn = f; imm = i;
  endtask

  task automatic rnd_f();
    set_f(2'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 6'($urandom), 16'($urandom));
  endtask

  // one clock: drive instance k, predict, advance model
  task automatic cyc(input int k, input bit v, input bit st,
                     input bit r, input bit lst,
                     input bit use_e, input logic [31:0] e);
    bit mr;
    exp_t x;
    valid[k] = v; start[k] = st; rst[k] = r; last = lst;
    mr = m_act[k] && (m_cnt[k] < DEP[k]);
    #1;
    chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(mr));
    if (r) begin
      m_act[k] = 0; m_done[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
    end else if (v && mr) begin
      x.a = 8'((BAS[k] + m_cnt[k]) % 256);
      x.d = use_e ? e : model_enc();
      x.c = ncyc + 1;
      if (k == 0) q0.push_back(x);
      else q1.push_back(x);
      m_cnt[k]++;
      if (lst) begin
        m_act[k] = 0; m_done[k] = 1;
      end else if (m_cnt[k] == DEP[k]) begin
        m_act[k] = 0; m_done[k] = 1; m_ovf[k] = 1;
      end
    end else if (st && !m_act[k]) begin
      m_act[k] = 1; m_done[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
    end
    @(posedge clk);
    #1;
    valid[k] = 0; start[k] = 0; rst[k] = 0; last = 0;
  endtask

  task automatic chk_st(input int k);
    chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(m_act[k]));
    chk($sformatf("done%0d", k), 64'(done[k]), 64'(m_done[k]));
    chk($sformatf("count%0d", k), 64'(cnt[k]), 64'(m_cnt[k]));
    chk($sformatf("ovf%0d", k), 64'(ovf[k]), 64'(m_ovf[k]));
  endtask

  task automatic chk_zero(input int k);
    chk("z_wr", 64'(wr[k]), 0);
    chk("z_addr", 64'(maddr[k]), 0);
    chk("z_data", 64'(mdata[k]), 0);
    chk("z_cnt", 64'(cnt[k]), 0);
    chk("z_busy", 64'(busy[k]), 0);
    chk("z_done", 64'(done[k]), 0);
    chk("z_ovf", 64'(ovf[k]), 0);
    chk("z_rdy", 64'(rdy[k]), 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) ||
            (k == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL wr_unexp inst=%0d got=%0h@%0h want=none",
                   k, mdata[k], maddr[k]);
        end else begin
          if (k == 0) mx = q0.pop_front();
          else mx = q1.pop_front();
          chk($sformatf("wr_addr%0d", k), 64'(maddr[k]), 64'(mx.a));
          chk($sformatf("wr_data%0d", k), 64'(mdata[k]), 64'(mx.d));
          chk($sformatf("wr_cyc%0d", k), 64'(ncyc), 64'(mx.c));
        end
      end
    end
  end

  initial begin
    int sent;
    bit v, st;
    for (int k = 0; k < 2; k++) begin
      valid[k] = 0; start[k] = 0; rst[k] = 1;
      m_cnt[k] = 0; m_act[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end
    set_f(0, 0, 0, 0, 0, 0);
    last = 0;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 0; rst[1] = 0;
    chk_zero(0);
    chk_zero(1);

    // R add as a one-word program
    cyc(0, 0, 1, 0, 0, 0, 0);
    set_f(0, 1, 2, 3, 6'h20, 0);
    cyc(0, 1, 0, 0, 1, 1, 32'h00221820);
    chk_st(0);

    // restart from DONE, lw / sw / beq back-to-back
    cyc(0, 0, 1, 0, 0, 0, 0);
    set_f(1, 29, 8, 0, 0, 16'd4);
    cyc(0, 1, 0, 0, 0, 1, 32'h8FA80004);
    set_f(2, 29, 8, 0, 0, 16'd8);
    cyc(0, 1, 0, 0, 0, 1, 32'hAFA80008);
    set_f(3, 1, 2, 0, 0, 16'hFFFF);
    cyc(0, 1, 0, 0, 1, 1, 32'h1022FFFF);
    chk("lsb_done", 64'(done[0]), 1);
    chk("lsb_count", 64'(cnt[0]), 3);
    chk_st(0);

    // 20 words, random gaps, stray start pulses mid-load
    cyc(0, 0, 1, 0, 0, 0, 0);
    sent = 0;
    while (sent < 20) begin
      rnd_f();
      v = 1'($urandom);
      st = ($urandom_range(0, 3) == 0);
      cyc(0, v, st, 0, v && (sent == 19), 0, 0);
      if (v) sent++;
    end
    chk_st(0);
    chk("rand_count", 64'(cnt[0]), 20);

    // start with valid in DONE: start taken, word dropped
    rnd_f();
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk_st(0);

    // one accepted word, then reset coinciding with the next word
    rnd_f();
    cyc(0, 1, 0, 0, 0, 0, 0);
    rnd_f();
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk_zero(0);
    rnd_f();
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk_zero(0);

    // DEPTH=4 overflow: five words, no last
    cyc(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      rnd_f();
      cyc(1, 1, 0, 0, 0, 0, 0);
    end
    chk_st(1);
    chk("ovf_flag", 64'(ovf[1]), 1);
    chk("ovf_cnt", 64'(cnt[1]), 4);

    // wrap 254,255,0 with last on third word
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk_st(1);
    for (int i = 0; i < 3; i++) begin
      rnd_f();
      cyc(1, 1, 0, 0, i == 2, 0, 0);
    end
    chk_st(1);

    // last on the DEPTH-th word: no overflow
    cyc(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rnd_f();
      cyc(1, 1, 0, 0, i == 3, 0, 0);
    end
    chk_st(1);
    chk("last_full_ovf", 64'(ovf[1]), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", 64'(q0.size()), 0);
    chk("q1_empty", 64'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
